// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and parameter legality check
// Purpose: receiver FSM state encoding plus a legality function that both the
//          receiver and the transmitter call on their parameters.
// Ports:   none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Legal frame shapes: 5..9 data bits, at least 4 clocks per bit so the
  // half-bit start check and mid-bit sampling still have room.
  function automatic bit uart_params_ok(input int data_bits, input int baud_div);
    return (data_bits >= 5) && (data_bits <= 9) && (baud_div >= 4);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - serial line and command handshake bundle for uart_rx_cfg
// Purpose: groups the RX line, the consumer ack and the received word/flags.
// Ports (signals):
//   RX       line into the receiver, idles high
//   clr_rdy  consumer ack, clears rdy and ovr_err
//   rdy      received word waiting in cmd
//   cmd      last received data word (DATA_BITS wide)
//   frm_err  stop bit of last committed frame was 0
//   par_err  parity mismatch on last committed frame
//   ovr_err  frame committed while rdy was still set
// Modports: master = line driver / consumer, slave = receiver.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);

  logic                 RX;
  logic                 clr_rdy;
  logic                 rdy;
  logic [DATA_BITS-1:0] cmd;
  logic                 frm_err;
  logic                 par_err;
  logic                 ovr_err;

  modport master (
    output RX, clr_rdy,
    input  rdy, cmd, frm_err, par_err, ovr_err
  );

  modport slave (
    input  RX, clr_rdy,
    output rdy, cmd, frm_err, par_err, ovr_err
  );

endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period down-counter shared by UART rx and tx
// Purpose: ticks when the counter reaches zero; reloads itself on tick so
//          consecutive ticks are BAUD_DIV clocks apart.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load_half_i restart so the next tick lands BAUD_DIV/2 + 1 clocks later
//   load_full_i restart so the next tick lands BAUD_DIV clocks later
//   tick_o      counter is zero this cycle
module uart_bit_timer #(
  parameter int BAUD_DIV = 109
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_half_i,
  input  logic load_full_i,
  output logic tick_o
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2);
  // Zero is a counted state, so a full period reloads with BAUD_DIV-1.
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (load_half_i) begin
      cnt_d = HALF_LOAD;
    end else if (load_full_i || tick_o) begin
      cnt_d = FULL_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver for the command path
// Purpose: synchronises RX, rejects short start glitches, samples each bit
//          mid-period and commits data plus framing/parity/overrun flags.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         uart_rx_cfg_if.slave (RX, clr_rdy in; rdy, cmd, *_err out)
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 109,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int LSB_FIRST  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_rx_cfg_if.slave bus
);

  import uart_pkg::*;

  if (!uart_params_ok(DATA_BITS, BAUD_DIV)) begin : g_bad_params
    $error("uart_rx_cfg: illegal DATA_BITS/BAUD_DIV");
  end

  localparam int BW = $clog2(DATA_BITS + 1);

  rx_state_t            state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] cmd_q, cmd_d;
  logic                 par_mis_q, par_mis_d;
  logic                 rdy_q, rdy_d;
  logic                 frm_q, frm_d;
  logic                 par_q, par_d;
  logic                 ovr_q, ovr_d;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic                 load_half, load_full, tick;
  logic                 start_edge, par_exp;

  // Two-flop synchroniser; rx_prev_q holds last cycle's rx_s for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.RX;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign start_edge = rx_prev_q & ~rx_s_q;
  assign par_exp    = (PARITY_ODD != 0) ? ~(^shift_q) : ^shift_q;

  uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_half_i (load_half),
    .load_full_i (load_full),
    .tick_o      (tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    cmd_d     = cmd_q;
    par_mis_d = par_mis_q;
    rdy_d     = rdy_q;
    frm_d     = frm_q;
    par_d     = par_q;
    ovr_d     = ovr_q;
    load_half = 1'b0;
    load_full = 1'b0;

    if (bus.clr_rdy) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          load_half = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s_q) begin
            state_d = IDLE;      // line back high at mid start bit: glitch
          end else begin
            load_full = 1'b1;
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (LSB_FIRST != 0) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          end else begin
            shift_d = {shift_q[DATA_BITS-2:0], rx_s_q};
          end
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
            end else begin
              state_d = STOP;
            end
          end
        end
      end
      PARITY: begin
        if (tick) begin
          par_mis_d = rx_s_q ^ par_exp;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          cmd_d   = shift_q;
          frm_d   = ~rx_s_q;
          par_d   = (PARITY_EN != 0) ? par_mis_q : 1'b0;
          rdy_d   = 1'b1;
          // A same-cycle ack consumed the previous word, so no overrun.
          ovr_d   = bus.clr_rdy ? 1'b0 : (ovr_q | rdy_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      cmd_q     <= '0;
      par_mis_q <= 1'b0;
      rdy_q     <= 1'b0;
      frm_q     <= 1'b0;
      par_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      cmd_q     <= cmd_d;
      par_mis_q <= par_mis_d;
      rdy_q     <= rdy_d;
      frm_q     <= frm_d;
      par_q     <= par_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.rdy     = rdy_q;
  assign bus.cmd     = cmd_q;
  assign bus.frm_err = frm_q;
  assign bus.par_err = par_q;
  assign bus.ovr_err = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;

  localparam int B = 109;
  // Start-bit pin edge to first cycle rdy reads 1: two sync flops, one cycle
  // comparing rx_s with its previous value, then B/2 + (bits+1)*B + 1.
  localparam int LAT_8N1 = 2 + 1 + (B / 2) + 9 * B + 1;
  localparam int LAT_8E1 = 2 + 1 + (B / 2) + 10 * B + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) bus ();
  uart_rx_cfg_if #(.DATA_BITS(8)) bus_p ();

  uart_rx_cfg #(.DATA_BITS(8), .BAUD_DIV(B), .PARITY_EN(0), .PARITY_ODD(0), .LSB_FIRST(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  uart_rx_cfg #(.DATA_BITS(8), .BAUD_DIV(B), .PARITY_EN(1), .PARITY_ODD(0), .LSB_FIRST(1)) dut_p (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_p)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int rise0 = 0;
  int rise1 = 0;
  logic rdy0_prev = 1'b0;
  logic rdy1_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rdy && !rdy0_prev) rise0 <= cyc;
    if (bus_p.rdy && !rdy1_prev) rise1 <= cyc;
    rdy0_prev <= bus.rdy;
    rdy1_prev <= bus_p.rdy;
  end

  task automatic drive_rx(input int which, input logic v);
    if (which == 0) bus.RX = v;
    else bus_p.RX = v;
  endtask

  task automatic hold_bit(input int which, input logic v);
    drive_rx(which, v);
    repeat (B) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input logic par_en,
                            input logic par_bit, input logic stop_bit);
    @(negedge clk);
    start_cyc = cyc;
    hold_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(which, data[i]);
    if (par_en) hold_bit(which, par_bit);
    hold_bit(which, stop_bit);
    drive_rx(which, 1'b1);
  endtask

  task automatic pulse_clr(input int which);
    @(negedge clk);
    if (which == 0) bus.clr_rdy = 1'b1;
    else bus_p.clr_rdy = 1'b1;
    @(negedge clk);
    bus.clr_rdy   = 1'b0;
    bus_p.clr_rdy = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", bus.rdy); end
    n_checks++; if (bus.cmd !== 8'h00) begin n_fail++; $display("FAIL reset_cmd: got %h want 00", bus.cmd); end
    n_checks++; if ({bus.frm_err, bus.par_err, bus.ovr_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.frm_err, bus.par_err, bus.ovr_err}); end
    n_checks++; if (dut.state_q !== uart_pkg::IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    n_checks++; if (rise0 - start_cyc !== LAT_8N1) begin
      n_fail++; $display("FAIL basic_latency: got %0d want %0d", rise0 - start_cyc, LAT_8N1); end
    n_checks++; if (bus.rdy !== 1'b1) begin n_fail++; $display("FAIL basic_rdy: got %b want 1", bus.rdy); end
    n_checks++; if (bus.cmd !== 8'hA5) begin n_fail++; $display("FAIL basic_cmd: got %h want a5", bus.cmd); end
    n_checks++; if ({bus.frm_err, bus.par_err, bus.ovr_err} !== 3'b000) begin
      n_fail++; $display("FAIL basic_flags: got %b want 000", {bus.frm_err, bus.par_err, bus.ovr_err}); end
    pulse_clr(0);
    n_checks++; if (bus.rdy !== 1'b0) begin n_fail++; $display("FAIL basic_clr: got %b want 0", bus.rdy); end
  endtask

  task automatic test_glitch;
    @(negedge clk);
    bus.RX = 1'b0;
    repeat (20) @(negedge clk);
    bus.RX = 1'b1;
    repeat (80) @(negedge clk);
    n_checks++; if (bus.rdy !== 1'b0) begin n_fail++; $display("FAIL glitch_rdy: got %b want 0", bus.rdy); end
    n_checks++; if (dut.state_q !== uart_pkg::IDLE) begin n_fail++; $display("FAIL glitch_state: got %0d want IDLE", dut.state_q); end
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.rdy !== 1'b1 || bus.cmd !== 8'h3C) begin
      n_fail++; $display("FAIL glitch_next: got rdy=%b cmd=%h want rdy=1 cmd=3c", bus.rdy, bus.cmd); end
    pulse_clr(0);
  endtask

  task automatic test_framing;
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bus.rdy !== 1'b1 || bus.cmd !== 8'h81) begin
      n_fail++; $display("FAIL frm_commit: got rdy=%b cmd=%h want rdy=1 cmd=81", bus.rdy, bus.cmd); end
    n_checks++; if (bus.frm_err !== 1'b1) begin n_fail++; $display("FAIL frm_set: got %b want 1", bus.frm_err); end
    pulse_clr(0);
    repeat (10) @(negedge clk);
    send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.frm_err !== 1'b0 || bus.cmd !== 8'h42) begin
      n_fail++; $display("FAIL frm_clear: got frm=%b cmd=%h want frm=0 cmd=42", bus.frm_err, bus.cmd); end
    pulse_clr(0);
  endtask

  task automatic test_parity;
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    n_checks++; if (rise1 - start_cyc !== LAT_8E1) begin
      n_fail++; $display("FAIL par_latency: got %0d want %0d", rise1 - start_cyc, LAT_8E1); end
    n_checks++; if (bus_p.par_err !== 1'b1 || bus_p.cmd !== 8'h03) begin
      n_fail++; $display("FAIL par_bad: got par=%b cmd=%h want par=1 cmd=03", bus_p.par_err, bus_p.cmd); end
    pulse_clr(1);
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
    n_checks++; if (bus_p.par_err !== 1'b0 || bus_p.frm_err !== 1'b0 || bus_p.rdy !== 1'b1) begin
      n_fail++; $display("FAIL par_good: got par=%b frm=%b rdy=%b want 0 0 1", bus_p.par_err, bus_p.frm_err, bus_p.rdy); end
    pulse_clr(1);
  endtask

  task automatic test_back_to_back;
    pulse_clr(0);
    n_checks++; if (bus.rdy !== 1'b0 || bus.cmd !== 8'h42 || bus.ovr_err !== 1'b0) begin
      n_fail++; $display("FAIL idle_clr: got rdy=%b cmd=%h ovr=%b want 0 42 0", bus.rdy, bus.cmd, bus.ovr_err); end
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.rdy !== 1'b1 || bus.ovr_err !== 1'b0 || bus.cmd !== 8'h11) begin
      n_fail++; $display("FAIL b2b_first: got rdy=%b ovr=%b cmd=%h want 1 0 11", bus.rdy, bus.ovr_err, bus.cmd); end
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.rdy !== 1'b1 || bus.ovr_err !== 1'b1 || bus.cmd !== 8'h22) begin
      n_fail++; $display("FAIL b2b_second: got rdy=%b ovr=%b cmd=%h want 1 1 22", bus.rdy, bus.ovr_err, bus.cmd); end
    pulse_clr(0);
    n_checks++; if (bus.rdy !== 1'b0 || bus.ovr_err !== 1'b0 || bus.cmd !== 8'h22) begin
      n_fail++; $display("FAIL b2b_clr: got rdy=%b ovr=%b cmd=%h want 0 0 22", bus.rdy, bus.ovr_err, bus.cmd); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    d = 8'h99;
    @(negedge clk);
    hold_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) hold_bit(0, d[i]);
    n_checks++; if (dut.state_q !== uart_pkg::DATA) begin n_fail++; $display("FAIL mid_state: got %0d want DATA", dut.state_q); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.rdy !== 1'b0 || bus.cmd !== 8'h00 || {bus.frm_err, bus.par_err, bus.ovr_err} !== 3'b000) begin
      n_fail++; $display("FAIL mid_reset: got rdy=%b cmd=%h flags=%b want 0 00 000", bus.rdy, bus.cmd,
                         {bus.frm_err, bus.par_err, bus.ovr_err}); end
    bus.RX = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * B) @(negedge clk);
    n_checks++; if (bus.rdy !== 1'b0) begin n_fail++; $display("FAIL mid_no_commit: got %b want 0", bus.rdy); end
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.rdy !== 1'b1 || bus.cmd !== 8'h5A || {bus.frm_err, bus.par_err, bus.ovr_err} !== 3'b000) begin
      n_fail++; $display("FAIL mid_next: got rdy=%b cmd=%h flags=%b want 1 5a 000", bus.rdy, bus.cmd,
                         {bus.frm_err, bus.par_err, bus.ovr_err}); end
  endtask

  initial begin
    bus.RX = 1'b1;
    bus.clr_rdy = 1'b0;
    bus_p.RX = 1'b1;
    bus_p.clr_rdy = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_parity();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
